mem_stage: RTL and testbench

//  Memory-access pipeline stage between EXE and WB of the 5-stage LoongArch core.
//  - Latches the EXE result bus; selects/extends load data from the synchronous data SRAM.
//  - Buffers SRAM read data when WB stalls.
//  - Drives the MEM->WB bus and the MEM-stage forwarding/hazard outputs to decode.

---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline: latches the EXE result bus,
// extracts and extends load data from the data SRAM, and holds that data while WB stalls.
module mem_stage #(
    parameter int IN_WD  = 76,
    parameter int OUT_WD = 70
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_to_mem_valid,
    input  logic [IN_WD-1:0]  exe_to_mem_bus,
    output logic              mem_allowin,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic [OUT_WD-1:0] mem_to_wb_bus,
    input  logic [31:0]       data_sram_rdata,
    output logic              gr_we_mem,
    output logic [4:0]        dest_mem,
    output logic [31:0]       forward_data_mem
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [IN_WD-1:0]   r_bus;
    logic [31:0]        r_hold;

    logic               w_valid;
    logic               w_ready_go;
    logic               w_load_in;
    logic [2:0]         w_ld_type;
    logic               w_load_op;
    logic               w_gr_we;
    logic [4:0]         w_dest;
    logic [31:0]        w_alu_result;
    logic [31:0]        w_pc;
    logic [1:0]         w_addr;
    logic [31:0]        w_raw;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_final_result;
    logic               w_unused_bits;

    assign w_ready_go = 1'b1;
    assign w_valid    = (r_state != EMPTY);
    assign mem_allowin     = ~w_valid | (w_ready_go & wb_allowin);
    assign mem_to_wb_valid = w_valid & w_ready_go;
    assign w_load_in  = exe_to_mem_valid & mem_allowin;

    assign w_ld_type    = r_bus[75:73];
    assign w_load_op    = r_bus[71];
    assign w_gr_we      = r_bus[70];
    assign w_dest       = r_bus[69:65];
    assign w_alu_result = r_bus[64:33];
    assign w_pc         = r_bus[32:1];
    assign w_addr       = w_alu_result[1:0];
    assign w_unused_bits = r_bus[72] ^ r_bus[0];

    // The SRAM only presents the word in the cycle after the request, so a
    // stalled load must keep its own copy in r_hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_bus   <= '0;
            r_hold  <= '0;
        end else if (w_load_in) begin
            r_state <= FRESH;
            r_bus   <= exe_to_mem_bus;
        end else begin
            case (r_state)
                EMPTY: r_state <= EMPTY;
                FRESH: begin
                    if (wb_allowin) begin
                        r_state <= EMPTY;
                    end else begin
                        r_state <= HELD;
                        r_hold  <= data_sram_rdata;
                    end
                end
                HELD: begin
                    if (wb_allowin) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    always_comb begin
        w_raw = (r_state == HELD) ? r_hold : data_sram_rdata;
        case (w_addr)
            2'd0:    w_byte = w_raw[7:0];
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
        w_half = w_addr[1] ? w_raw[31:16] : w_raw[15:0];
        // Unrecognised ld_type codes fall back to the ALU result.
        case (w_ld_type)
            3'b001:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b101:  w_load_data = {24'd0, w_byte};
            3'b010:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b110:  w_load_data = {16'd0, w_half};
            3'b011:  w_load_data = w_raw;
            default: w_load_data = w_alu_result;
        endcase
        w_final_result = w_load_op ? w_load_data : w_alu_result;
    end

    assign mem_to_wb_bus    = {w_gr_we, w_dest, w_final_result, w_pc};
    assign gr_we_mem        = w_valid & w_gr_we;
    assign dest_mem         = w_valid ? w_dest : 5'd0;
    assign forward_data_mem = w_valid ? w_final_result : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver pushes the expected WB bus of every
// accepted instruction, and a negedge monitor pops and compares on each WB handshake.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        exe_to_mem_valid;
    logic [75:0] exe_to_mem_bus;
    logic        mem_allowin;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic        gr_we_mem;
    logic [4:0]  dest_mem;
    logic [31:0] forward_data_mem;

    int          testsRun;
    int          testsFailed;
    logic [69:0] sbq[$];
    logic        fresh;
    logic        accepted;
    logic [31:0] pendingWord;
    logic [31:0] nextWord;

    mem_stage #(.IN_WD(76), .OUT_WD(70)) dut (
        .clk              (clk),
        .reset            (reset),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .mem_allowin      (mem_allowin),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .data_sram_rdata  (data_sram_rdata),
        .gr_we_mem        (gr_we_mem),
        .dest_mem         (dest_mem),
        .forward_data_mem (forward_data_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(string name, logic [69:0] actual, logic [69:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endfunction

    // Reference result: pick the addressed byte/half with shifts and masks, then extend.
    function automatic logic [69:0] makeExpected(logic [75:0] bus, logic [31:0] word);
        logic [2:0]  ldType;
        logic [31:0] alu;
        logic [31:0] res;
        int unsigned v;
        ldType = bus[75:73];
        alu    = bus[64:33];
        res    = alu;
        if (bus[71]) begin
            if (ldType == 3'd1 || ldType == 3'd5) begin
                v = (word >> (8 * int'(alu[1:0]))) & 32'hFF;
                if (ldType == 3'd1 && v >= 128) v = v + 32'hFFFF_FF00;
                res = v;
            end else if (ldType == 3'd2 || ldType == 3'd6) begin
                v = (word >> (16 * int'(alu[1]))) & 32'hFFFF;
                if (ldType == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
                res = v;
            end else if (ldType == 3'd3) begin
                res = word;
            end
        end
        return {bus[70], bus[69:65], res, bus[32:1]};
    endfunction

    function automatic logic [75:0] makeBus(logic [2:0] ldType, logic loadOp, logic grWe,
                                            logic [4:0] dest, logic [31:0] alu, logic [31:0] pc);
        logic lu12i;
        logic rsvd;
        lu12i = 1'($urandom());
        rsvd  = 1'($urandom());
        return {ldType, lu12i, loadOp, grWe, dest, alu, pc, rsvd};
    endfunction

    // Monitor: compares the head of the scoreboard whenever MEM should hold an instruction.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("mem_allowin", 70'(mem_allowin), 70'((sbq.size() == 0) || wb_allowin));
            checkOutput("mem_to_wb_valid", 70'(mem_to_wb_valid), 70'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                checkOutput("mem_to_wb_bus", mem_to_wb_bus, sbq[0]);
                checkOutput("gr_we_mem", 70'(gr_we_mem), 70'(sbq[0][69]));
                checkOutput("dest_mem", 70'(dest_mem), 70'(sbq[0][68:64]));
                checkOutput("forward_data_mem", 70'(forward_data_mem), 70'(sbq[0][63:32]));
                if (wb_allowin) void'(sbq.pop_front());
            end else begin
                checkOutput("idle_gr_we_mem", 70'(gr_we_mem), 70'd0);
                checkOutput("idle_dest_mem", 70'(dest_mem), 70'd0);
                checkOutput("idle_forward", 70'(forward_data_mem), 70'd0);
            end
        end
    end

    task automatic driveInputs(input logic v, input logic [75:0] bus, input logic wbA, input logic [31:0] word);
        data_sram_rdata  = fresh ? pendingWord : $urandom();
        exe_to_mem_valid = v;
        exe_to_mem_bus   = bus;
        wb_allowin       = wbA;
        accepted         = v && ((sbq.size() == 0) || wbA);
        nextWord         = word;
    endtask

    task automatic commitCycle();
        @(posedge clk);
        fresh = accepted;
        if (accepted) begin
            pendingWord = nextWord;
            sbq.push_back(makeExpected(exe_to_mem_bus, nextWord));
        end
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [75:0] bus, input logic wbA, input logic [31:0] word);
        driveInputs(v, bus, wbA, word);
        commitCycle();
    endtask

    task automatic checkResult(input string name, input logic [31:0] lit);
        @(negedge clk);
        checkOutput(name, 70'(forward_data_mem), 70'(lit));
    endtask

    // Asserts reset between edges and checks the outputs clear before the next edge.
    task automatic doReset();
        #1 reset = 1'b1;
        exe_to_mem_valid = 1'b0;
        wb_allowin       = 1'b0;
        #1;
        checkOutput("rst_mem_allowin", 70'(mem_allowin), 70'd1);
        checkOutput("rst_valid", 70'(mem_to_wb_valid), 70'd0);
        checkOutput("rst_bus", mem_to_wb_bus, 70'd0);
        checkOutput("rst_gr_we_mem", 70'(gr_we_mem), 70'd0);
        checkOutput("rst_dest_mem", 70'(dest_mem), 70'd0);
        checkOutput("rst_forward", 70'(forward_data_mem), 70'd0);
        sbq.delete();
        fresh = 1'b0;
        #1 reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [75:0] dirBus[6];
        logic [31:0] dirWord[6];
        logic [31:0] dirLit[6];
        logic [2:0]  codes[5];
        logic [2:0]  ld;
        int          kind;

        testsRun         = 0;
        testsFailed      = 0;
        reset            = 1'b1;
        exe_to_mem_valid = 1'b0;
        exe_to_mem_bus   = '0;
        wb_allowin       = 1'b0;
        data_sram_rdata  = '0;
        fresh            = 1'b0;
        accepted         = 1'b0;
        pendingWord      = '0;
        nextWord         = '0;
        codes[0] = 3'd1; codes[1] = 3'd5; codes[2] = 3'd2; codes[3] = 3'd6; codes[4] = 3'd3;

        @(posedge clk);
        #1;
        doReset();

        // Back-to-back loads and ALU results with WB always accepting.
        dirBus[0] = makeBus(3'd3, 1'b1, 1'b1, 5'd4, 32'h0000_1000, 32'h1C00_0000); dirWord[0] = 32'hDEAD_BEEF; dirLit[0] = 32'hDEAD_BEEF;
        dirBus[1] = makeBus(3'd1, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h1C00_0004); dirWord[1] = 32'h80FF_1234; dirLit[1] = 32'hFFFF_FF80;
        dirBus[2] = makeBus(3'd5, 1'b1, 1'b1, 5'd6, 32'h0000_1003, 32'h1C00_0008); dirWord[2] = 32'h80FF_1234; dirLit[2] = 32'h0000_0080;
        dirBus[3] = makeBus(3'd6, 1'b1, 1'b1, 5'd7, 32'h0000_1002, 32'h1C00_000C); dirWord[3] = 32'h80FF_1234; dirLit[3] = 32'h0000_80FF;
        dirBus[4] = makeBus(3'd0, 1'b0, 1'b1, 5'd8, 32'h0000_0005, 32'h1C00_0010); dirWord[4] = 32'h1111_1111; dirLit[4] = 32'h0000_0005;
        dirBus[5] = makeBus(3'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0007, 32'h1C00_0014); dirWord[5] = 32'h2222_2222; dirLit[5] = 32'h0000_0007;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) driveInputs(1'b1, dirBus[i], 1'b1, dirWord[i]);
            else       driveInputs(1'b0, '0, 1'b1, 32'd0);
            if (i > 0) checkResult($sformatf("directed_%0d", i - 1), dirLit[i - 1]);
            commitCycle();
        end

        // ld.h held for three stalled cycles while the SRAM word changes underneath.
        applyStimulus(1'b1, makeBus(3'd2, 1'b1, 1'b1, 5'd10, 32'h0000_1000, 32'h1C00_0020), 1'b1, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            driveInputs(1'b1, makeBus(3'd0, 1'b0, 1'b1, 5'd11, $urandom(), $urandom()), 1'b0, 32'd0);
            checkResult("ldh_stalled", 32'hFFFF_ABCD);
            commitCycle();
        end
        driveInputs(1'b0, '0, 1'b1, 32'd0);
        checkResult("ldh_accepted", 32'hFFFF_ABCD);
        commitCycle();

        // Reset while a load is held, then normal operation resumes.
        applyStimulus(1'b1, makeBus(3'd3, 1'b1, 1'b1, 5'd12, 32'h0000_2000, 32'h1C00_0030), 1'b1, 32'h1234_5678);
        applyStimulus(1'b0, '0, 1'b0, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 32'd0);
        doReset();
        applyStimulus(1'b1, makeBus(3'd0, 1'b0, 1'b1, 5'd13, 32'h0000_0042, 32'h1C00_0040), 1'b1, 32'd0);
        driveInputs(1'b0, '0, 1'b1, 32'd0);
        checkResult("after_reset", 32'h0000_0042);
        commitCycle();

        // Randomised traffic with random EXE validity and WB back-pressure.
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 5);
            ld   = (kind < 5) ? codes[kind] : 3'd0;
            applyStimulus(($urandom_range(0, 9) < 6),
                          makeBus(ld, (kind < 5), 1'($urandom()), 5'($urandom()), $urandom(), $urandom()),
                          ($urandom_range(0, 9) < 7), $urandom());
        end
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, '0, 1'b1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
